stream_packet_fifo: RTL and testbench
=====================================

// Module: stream_packet_fifo
// PURPOSE
//  Store-and-forward packet FIFO placed directly downstream of the QoS stream arbiter.
//  - Buffers arbitrated beats {data, qos, id, last}.
//  - Presents a packet on the master side only once its last beat has been stored.
//  - Downstream sinks therefore never see a packet stall mid-burst because of a slow source.
//  - Cut-through fallback: packets longer than DEPTH still drain, so the FIFO cannot deadlock.
// PARAMETERS
//  T_DATA_WIDTH  8                     data beat width
//  T_QOS__WIDTH  4                     QoS field width
//  STREAM_COUNT  2                     number of arbitrated sources
//  T_ID___WIDTH  $clog2(STREAM_COUNT)  source id width
//  DEPTH         8                     entries; power of 2, >=2
//  CNT_W         $clog2(DEPTH+1)       level/packet counter width (derived)
// PORTS
//  clk_i        in   1             clock, all logic on rising edge
//  rst_i        in   1             asynchronous reset, active high
//  s_data_i     in   T_DATA_WIDTH  input beat data
//  s_qos_i      in   T_QOS__WIDTH  input beat QoS
//  s_id_i       in   T_ID___WIDTH  input beat source id
//  s_last_i     in   1             last beat of packet
//  s_valid_i    in   1             input beat valid
//  s_ready_o    out  1             FIFO can accept a beat
//  m_data_o     out  T_DATA_WIDTH  output beat data
//  m_qos_o      out  T_QOS__WIDTH  output beat QoS
//  m_id_o       out  T_ID___WIDTH  output beat source id
//  m_last_o     out  1             output last beat
//  m_valid_o    out  1             output beat valid
//  m_ready_i    in   1             downstream accepts beat
//  level_o      out  CNT_W         stored beats, 0..DEPTH
//  pkt_count_o  out  CNT_W         complete packets stored (last beat present)
// BEHAVIOUR
//  Reset (rst_i high, asynchronous, takes effect immediately, including mid-packet):
//  - rd/wr pointers, level, pkt_count and ct flag all go to 0.
//  - s_ready_o=0 and m_valid_o=0 while rst_i is high.
//  - Memory contents are not reset.
//  - After release: s_ready_o=1 at the first rising edge.
//  Input handshake:
//  - push = s_valid_i & s_ready_o.
//  - s_ready_o = (level != DEPTH), registered-state-based.
//  - No full-bypass: when full, s_ready_o=0 even if a pop occurs in the same cycle.
//  Output handshake (FWFT):
//  - pop = m_valid_o & m_ready_i.
//  - m_* come combinationally from the entry at rd_ptr.
//  - m_* are forced to 0 whenever m_valid_o=0.
//  - m_* are held stable while m_valid_o=1 and m_ready_i=0.
//  - m_valid_o = (level!=0) & (pkt_count!=0 | ct).
//  Latency: a last beat accepted at edge N makes its packet visible (m_valid_o=1) after edge N, i.e. cycle N+1.
//  Counters:
//  - level: +1 on push, -1 on pop, unchanged on both.
//  - pkt_count: +1 on push with s_last_i, -1 on pop with m_last_o, unchanged on both.
//  - Neither counter ever wraps; pointers wrap modulo DEPTH.
//  Cut-through state (ct):
//  - IDLE -> CT when level==DEPTH and pkt_count==0 (oversize packet).
//  - CT -> IDLE on a pop with m_last_o=1.
//  - In CT the head packet streams beat by beat as it arrives; order is preserved.
//  Ordering: strict FIFO; id/qos travel unchanged with each beat.
//  No reordering, dropping or QoS-based priority inside this block.
// TESTING
//  1. Reset mid-packet (2 of 4 beats stored)
//     -> level_o=0, pkt_count_o=0, m_valid_o=0, s_ready_o=0 during reset; s_ready_o=1 one edge after release.
//  2. Push 0x11,0x22,0x33(last), id=1, qos=5, m_ready_i=1
//     -> m_valid_o=0 until the edge after 0x33 is accepted; then 3 consecutive beats, m_last_o only on 0x33.
//  3. m_ready_i=0, push two 4-beat packets
//     -> level_o=8, pkt_count_o=2, s_ready_o=0; one pop -> s_ready_o=1 next cycle, level_o=7.
//  4. 10-beat packet, m_ready_i=0 until full, then 1
//     -> ct engages at level 8, pkt_count 0; all 10 beats emerge in order; ct clears after last pop.
//  5. Random s_valid_i/m_ready_i (50%), 200 packets of 1..6 beats
//     -> scoreboard matches data/qos/id/last; m_* stable while stalled.
//  6. Push last and pop last in the same cycle
//     -> pkt_count_o unchanged; level_o unchanged.

Source files
------------

// File: rtl/stream_packet_fifo.sv
// Store-and-forward packet FIFO for the arbitrated stream.
// A packet is offered downstream only once its last beat is stored. A packet
// longer than the FIFO switches to cut-through so the FIFO cannot deadlock.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | store-and-forward: head is released only when complete
// ST_CT   | cut-through: oversize head packet streams as beats arrive
module stream_packet_fifo #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID___WIDTH = (STREAM_COUNT > 1) ? $clog2(STREAM_COUNT) : 1,
  parameter int DEPTH        = 8,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_QOS__WIDTH-1:0] s_qos_i,
  input  logic [T_ID___WIDTH-1:0] s_id_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_QOS__WIDTH-1:0] m_qos_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [CNT_W-1:0]        level_o,
  output logic [CNT_W-1:0]        pkt_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = T_DATA_WIDTH + T_QOS__WIDTH + T_ID___WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CT   = 1'b1
  } state_t;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  state_t           state_q, state_d;
  logic             init_q;
  logic             push, pop;
  logic [EW-1:0]    head;

  // init_q keeps s_ready_o low until the first edge after reset release.
  assign s_ready_o = init_q & (level_q != FULL_LVL);
  assign m_valid_o = (level_q != '0) & ((pkt_q != '0) | (state_q == ST_CT));
  assign push      = s_valid_i & s_ready_o;
  assign pop       = m_valid_o & m_ready_i;

  assign head = mem_q[rd_ptr_q];
  assign {m_data_o, m_qos_o, m_id_o, m_last_o} = m_valid_o ? head : '0;

  assign level_o     = level_q;
  assign pkt_count_o = pkt_q;

  // Next-state for pointers, counters and the cut-through state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;
    state_d  = state_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    case ({push & s_last_i, pop & m_last_o})
      2'b10:   pkt_d = pkt_q + 1'b1;
      2'b01:   pkt_d = pkt_q - 1'b1;
      default: pkt_d = pkt_q;
    endcase

    // Full with no complete packet can only mean an oversize head packet.
    case (state_q)
      ST_IDLE: if (level_q == FULL_LVL && pkt_q == '0) state_d = ST_CT;
      ST_CT:   if (pop && m_last_o) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers; reset clears everything except the storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
      state_q  <= ST_IDLE;
      init_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
      state_q  <= state_d;
      init_q   <= 1'b1;
    end
  end

  // Beat storage, written on accepted input beats; never reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {s_data_i, s_qos_i, s_id_i, s_last_i};
  end

endmodule

// File: tb/tb_stream_packet_fifo.sv
module tb_stream_packet_fifo;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] q;
    logic       id;
    logic       last;
  } beat_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] s_data_i;
  logic [3:0] s_qos_i;
  logic       s_id_i;
  logic       s_last_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic [3:0] m_qos_o;
  logic       m_id_o;
  logic       m_last_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic [3:0] level_o;
  logic [3:0] pkt_count_o;

  int checks = 0;
  int errors = 0;

  stream_packet_fifo #(
    .T_DATA_WIDTH(8), .T_QOS__WIDTH(4), .STREAM_COUNT(2), .DEPTH(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_data_i(s_data_i), .s_qos_i(s_qos_i), .s_id_i(s_id_i), .s_last_i(s_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_qos_o(m_qos_o), .m_id_o(m_id_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .level_o(level_o), .pkt_count_o(pkt_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; s_valid_i = 0; s_data_i = 0; s_qos_i = 0; s_id_i = 0; s_last_i = 0; m_ready_i = 0;
    step(); step();
    checks++; if (level_o !== 4'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level_o); end
    checks++; if (pkt_count_o !== 4'd0) begin errors++; $display("FAIL rst_pkt got=%0d exp=0", pkt_count_o); end
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mvalid got=%b exp=0", m_valid_o); end
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL rst_sready got=%b exp=0", s_ready_o); end
    rst_i = 1'b0;
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL rel_sready_pre got=%b exp=0", s_ready_o); end
    step();
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL rel_sready got=%b exp=1", s_ready_o); end
    // two beats of a four-beat packet, then reset mid-packet
    s_valid_i = 1; s_data_i = 8'h01; s_qos_i = 4'h1;
    step();
    s_data_i = 8'h02;
    step();
    s_valid_i = 0;
    checks++; if (level_o !== 4'd2) begin errors++; $display("FAIL mid_level got=%0d exp=2", level_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if (level_o !== 4'd0) begin errors++; $display("FAIL mid_rst_level got=%0d exp=0", level_o); end
    checks++; if (pkt_count_o !== 4'd0) begin errors++; $display("FAIL mid_rst_pkt got=%0d exp=0", pkt_count_o); end
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_mvalid got=%b exp=0", m_valid_o); end
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL mid_rst_sready got=%b exp=0", s_ready_o); end
    step();
    rst_i = 1'b0;
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL mid_rel_pre got=%b exp=0", s_ready_o); end
    step();
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL mid_rel_sready got=%b exp=1", s_ready_o); end
    checks++; if (level_o !== 4'd0) begin errors++; $display("FAIL mid_rel_level got=%0d exp=0", level_o); end
  endtask

  task automatic test_basic();
    logic [7:0] d [3];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    m_ready_i = 1; s_valid_i = 1; s_id_i = 1; s_qos_i = 4'h5;
    for (int i = 0; i < 3; i++) begin
      s_data_i = d[i]; s_last_i = (i == 2);
      checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL basic_wait%0d got=%b exp=0", i, m_valid_o); end
      step();
    end
    s_valid_i = 0; s_last_i = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== d[i] || m_last_o !== (i == 2) || m_id_o !== 1'b1 || m_qos_o !== 4'h5) begin
        errors++;
        $display("FAIL basic_out%0d got v=%b d=%h l=%b id=%b q=%h exp v=1 d=%h l=%b id=1 q=5",
                 i, m_valid_o, m_data_o, m_last_o, m_id_o, m_qos_o, d[i], (i == 2));
      end
      step();
    end
    checks++; if (m_valid_o !== 1'b0 || level_o !== 4'd0 || pkt_count_o !== 4'd0) begin
      errors++; $display("FAIL basic_empty got v=%b lvl=%0d pkt=%0d exp 0/0/0", m_valid_o, level_o, pkt_count_o); end
    m_ready_i = 0;
  endtask

  task automatic test_full();
    logic [7:0] e;
    m_ready_i = 0; s_valid_i = 1;
    for (int i = 0; i < 8; i++) begin
      s_data_i = 8'((i < 4) ? (8'hA0 + i) : (8'hAC + i));
      s_last_i = (i == 3 || i == 7);
      s_id_i = (i >= 4);
      s_qos_i = 4'(i);
      step();
    end
    s_data_i = 8'hEE; s_last_i = 1;
    checks++; if (level_o !== 4'd8) begin errors++; $display("FAIL full_level got=%0d exp=8", level_o); end
    checks++; if (pkt_count_o !== 4'd2) begin errors++; $display("FAIL full_pkt got=%0d exp=2", pkt_count_o); end
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL full_sready got=%b exp=0", s_ready_o); end
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'hA0) begin errors++; $display("FAIL full_head got v=%b d=%h exp v=1 d=a0", m_valid_o, m_data_o); end
    m_ready_i = 1;
    step();
    checks++; if (level_o !== 4'd7) begin errors++; $display("FAIL full_pop_level got=%0d exp=7", level_o); end
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL full_pop_sready got=%b exp=1", s_ready_o); end
    s_valid_i = 0; s_last_i = 0;
    for (int j = 1; j < 8; j++) begin
      e = 8'((j < 4) ? (8'hA0 + j) : (8'hAC + j));
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== e || m_last_o !== (j == 3 || j == 7) || m_id_o !== (j >= 4) || m_qos_o !== 4'(j)) begin
        errors++;
        $display("FAIL full_drain%0d got v=%b d=%h l=%b id=%b q=%h exp d=%h", j, m_valid_o, m_data_o, m_last_o, m_id_o, m_qos_o, e);
      end
      step();
    end
    checks++; if (m_valid_o !== 1'b0 || level_o !== 4'd0 || pkt_count_o !== 4'd0) begin
      errors++; $display("FAIL full_empty got v=%b lvl=%0d pkt=%0d exp 0/0/0", m_valid_o, level_o, pkt_count_o); end
    m_ready_i = 0;
  endtask

  task automatic test_cut_through();
    int in_idx, out_idx;
    bit push, pop;
    m_ready_i = 0; s_valid_i = 1; s_id_i = 0; s_qos_i = 4'h9; s_last_i = 0;
    for (int i = 0; i < 8; i++) begin
      s_data_i = 8'(8'h40 + i);
      step();
    end
    s_data_i = 8'h48;
    checks++; if (level_o !== 4'd8 || pkt_count_o !== 4'd0) begin errors++; $display("FAIL ct_full got lvl=%0d pkt=%0d exp 8/0", level_o, pkt_count_o); end
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL ct_pre_valid got=%b exp=0", m_valid_o); end
    step();
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'h40) begin errors++; $display("FAIL ct_engage got v=%b d=%h exp v=1 d=40", m_valid_o, m_data_o); end
    in_idx = 8; out_idx = 0; m_ready_i = 1;
    for (int cyc = 0; cyc < 60 && out_idx < 10; cyc++) begin
      s_valid_i = (in_idx < 10);
      s_data_i = 8'(8'h40 + in_idx);
      s_last_i = (in_idx == 9);
      push = s_valid_i && s_ready_o;
      pop = m_valid_o && m_ready_i;
      if (pop) begin
        checks++;
        if (m_data_o !== 8'(8'h40 + out_idx) || m_last_o !== (out_idx == 9)) begin
          errors++; $display("FAIL ct_beat%0d got d=%h l=%b exp d=%h l=%b", out_idx, m_data_o, m_last_o, 8'(8'h40 + out_idx), (out_idx == 9));
        end
        out_idx++;
      end
      step();
      if (push) in_idx++;
    end
    s_valid_i = 0; s_last_i = 0;
    checks++; if (out_idx != 10) begin errors++; $display("FAIL ct_timeout got=%0d beats exp=10", out_idx); end
    checks++; if (m_valid_o !== 1'b0 || level_o !== 4'd0 || pkt_count_o !== 4'd0) begin
      errors++; $display("FAIL ct_empty got v=%b lvl=%0d pkt=%0d exp 0/0/0", m_valid_o, level_o, pkt_count_o); end
    // with ct cleared a partial packet must be held back again
    m_ready_i = 0; s_valid_i = 1; s_data_i = 8'h4F;
    step();
    s_data_i = 8'h50; s_last_i = 1; s_valid_i = 0;
    checks++; if (level_o !== 4'd1 || m_valid_o !== 1'b0) begin errors++; $display("FAIL ct_cleared got lvl=%0d v=%b exp 1/0", level_o, m_valid_o); end
    s_valid_i = 1;
    step();
    s_valid_i = 0; s_last_i = 0;
    checks++; if (m_valid_o !== 1'b1 || m_data_o !== 8'h4F) begin errors++; $display("FAIL ct_after got v=%b d=%h exp v=1 d=4f", m_valid_o, m_data_o); end
    m_ready_i = 1;
    step(); step();
    checks++; if (level_o !== 4'd0 || pkt_count_o !== 4'd0) begin errors++; $display("FAIL ct_after_drain got lvl=%0d pkt=%0d exp 0/0", level_o, pkt_count_o); end
    m_ready_i = 0;
  endtask

  task automatic test_simultaneous();
    m_ready_i = 0; s_valid_i = 1; s_data_i = 8'h61; s_last_i = 1; s_id_i = 1; s_qos_i = 4'h3;
    step();
    checks++; if (level_o !== 4'd1 || pkt_count_o !== 4'd1 || m_data_o !== 8'h61) begin
      errors++; $display("FAIL simul_setup got lvl=%0d pkt=%0d d=%h exp 1/1/61", level_o, pkt_count_o, m_data_o); end
    s_data_i = 8'h62; m_ready_i = 1;
    step();
    s_valid_i = 0; s_last_i = 0;
    checks++; if (level_o !== 4'd1) begin errors++; $display("FAIL simul_level got=%0d exp=1", level_o); end
    checks++; if (pkt_count_o !== 4'd1) begin errors++; $display("FAIL simul_pkt got=%0d exp=1", pkt_count_o); end
    checks++; if (m_data_o !== 8'h62 || m_last_o !== 1'b1) begin errors++; $display("FAIL simul_head got d=%h l=%b exp 62/1", m_data_o, m_last_o); end
    step();
    checks++; if (level_o !== 4'd0 || m_valid_o !== 1'b0) begin errors++; $display("FAIL simul_drain got lvl=%0d v=%b exp 0/0", level_o, m_valid_o); end
    m_ready_i = 0;
  endtask

  task automatic test_random();
    beat_t sb[$];
    beat_t cur, exp_b, held, got;
    int pkts_left, beats_left;
    bit have_beat, held_valid, push, pop, done;
    logic cur_id;
    logic [3:0] cur_q;
    pkts_left = 200; beats_left = 0; have_beat = 0; held_valid = 0; done = 0;
    cur = '0; held = '0; cur_id = 0; cur_q = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (pkts_left == 0 && !have_beat && sb.size() == 0) begin done = 1; break; end
      if (!have_beat && pkts_left > 0) begin
        if (beats_left == 0) begin
          beats_left = $urandom_range(1, 6);
          cur_id = 1'($urandom_range(0, 1));
          cur_q = 4'($urandom_range(0, 15));
        end
        cur.d = 8'($urandom); cur.q = cur_q; cur.id = cur_id; cur.last = (beats_left == 1);
        have_beat = 1;
      end
      s_valid_i = have_beat && ($urandom_range(0, 1) == 1);
      s_data_i = cur.d; s_qos_i = cur.q; s_id_i = cur.id; s_last_i = cur.last;
      m_ready_i = ($urandom_range(0, 1) == 1);
      got = {m_data_o, m_qos_o, m_id_o, m_last_o};
      if (held_valid) begin
        checks++;
        if (m_valid_o !== 1'b1 || got !== held) begin
          errors++; $display("FAIL rand_stall got v=%b beat=%h exp v=1 beat=%h", m_valid_o, got, held);
        end
      end
      push = s_valid_i && s_ready_o;
      pop = m_valid_o && m_ready_i;
      if (pop) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_underflow got beat=%h exp none", got);
        end else begin
          exp_b = sb.pop_front();
          if (got !== exp_b) begin errors++; $display("FAIL rand_beat got=%h exp=%h", got, exp_b); end
        end
      end
      if (push) begin
        sb.push_back(cur);
        have_beat = 0;
        beats_left--;
        if (beats_left == 0) pkts_left--;
      end
      held_valid = m_valid_o && !m_ready_i;
      held = got;
      step();
    end
    s_valid_i = 0; s_last_i = 0; m_ready_i = 0;
    checks++; if (!done) begin errors++; $display("FAIL rand_timeout got pkts_left=%0d queued=%0d exp 0/0", pkts_left, sb.size()); end
    checks++; if (level_o !== 4'd0 || pkt_count_o !== 4'd0) begin
      errors++; $display("FAIL rand_empty got lvl=%0d pkt=%0d exp 0/0", level_o, pkt_count_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_cut_through();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
